// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//   Serial adder/subtractor. It uses a single 4-bit carry-lookahead slice and
//   processes one nibble per clock, starting with the LSB nibble. An operation
//   takes exactly NIBBLES cycles from accept to out_valid.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   a, b       : W-bit operands, sampled only on accept
//   sub        : 0 = a+b, 1 = a-b, sampled only on accept
//   in_valid   : request present
//   in_ready   : block is idle and can accept a request
//   sum        : W-bit result, held until the next operation completes
//   cout       : carry out of bit W-1 (for subtract, 1 = no borrow)
//   overflow   : two's-complement overflow
//   zero       : sum == 0
//   out_valid  : result and flags valid
//   out_ready  : consumer takes the result
//
// Also contains cla_full: the combinational 4-bit CLA slice.
// ---------------------------------------------------------------------------

module cla_full (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Fully expanded lookahead carries. No carry ripples through the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 sub,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 overflow,
  output logic                 zero,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_reg;
  logic [IDXW-1:0] idx_reg;
  logic            carry_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;      // B already inverted for subtract
  logic [W-1:0]    acc_reg;
  logic [W-1:0]    sum_reg;
  logic            cout_reg;
  logic            overflow_reg;
  logic            zero_reg;

  logic [3:0]      a_nib [NIBBLES];
  logic [3:0]      b_nib [NIBBLES];
  logic [3:0]      slice_sum;
  logic            slice_cout;
  logic [W-1:0]    final_sum;
  logic            last_nibble;

  // final_sum is the accumulator with the current nibble replaced by the
  // slice output. On the last CALC edge, this is the complete result. This
  // lets the flags be computed in the same edge that stores the last nibble.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[gi*4 +: 4];
    assign b_nib[gi] = b_reg[gi*4 +: 4];
    assign final_sum[gi*4 +: 4] = (idx_reg == IDXW'(gi)) ? slice_sum
                                                          : acc_reg[gi*4 +: 4];
  end

  cla_full u_slice (
    .a    (a_nib[idx_reg]),
    .b    (b_nib[idx_reg]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_nibble = (idx_reg == IDXW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b ^ {W{sub}};
            carry_reg <= sub;          // +1 completes two's-complement negate
            idx_reg   <= '0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          acc_reg   <= final_sum;
          carry_reg <= slice_cout;
          if (last_nibble) begin
            sum_reg      <= final_sum;
            cout_reg     <= slice_cout;
            overflow_reg <= (a_reg[W-1] == b_reg[W-1]) &&
                            (final_sum[W-1] != a_reg[W-1]);
            zero_reg     <= (final_sum == '0);
            idx_reg      <= '0;
            state_reg    <= DONE;
          end else begin
            idx_reg <= idx_reg + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (NIBBLES = 4). It uses table-driven
// vectors and adds hand-written backpressure and reset-during-CALC sequences.
module tb_nibble_serial_adder;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         sub;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         cout, overflow, zero;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[11];

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one operation. The result is left in DONE (out_ready low) on return.
  task automatic start_and_wait(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, " in_ready_before_accept"}, W'(in_ready), W'(1));
    @(posedge clk);                     // accept edge T
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = ~sub;  // must not disturb the op
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, W'(lat), W'(NIB));
    chk({tag, " sum"},      sum,          v.exp_sum);
    chk({tag, " cout"},     W'(cout),     W'(v.exp_cout));
    chk({tag, " overflow"}, W'(overflow), W'(v.exp_ovf));
    chk({tag, " zero"},     W'(zero),     W'(v.exp_zero));
    $display("op %s: a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
             tag, v.a, v.b, v.sub, sum, cout, overflow, zero, lat);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " in_ready_after_release"},  W'(in_ready),  W'(1));
    chk({tag, " out_valid_after_release"}, W'(out_valid), W'(0));
  endtask

  initial begin
    //          a        b        sub   sum      cout  ovf   zero
    vecs[0]  = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; a = '0; b = '0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready",  W'(in_ready),  W'(1));
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset sum",       sum,           W'(0));
    chk("reset flags",     W'({cout, overflow, zero}), W'(0));
    $display("reset: in_ready=%0d out_valid=%0d sum=%h", in_ready, out_valid, sum);

    for (int i = 0; i < 11; i++) begin
      start_and_wait(vecs[i], $sformatf("vec%0d", i));
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: hold DONE for 3 cycles while the inputs are noisy.
    start_and_wait(vecs[0], "bp");
    for (int k = 0; k < 3; k++) begin
      in_valid = ~in_valid; a = W'($urandom); b = W'($urandom); sub = ~sub;
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", k), W'(out_valid), W'(1));
      chk($sformatf("bp%0d in_ready", k),  W'(in_ready),  W'(0));
      chk($sformatf("bp%0d sum", k),       sum,           16'h2201);
      chk($sformatf("bp%0d flags", k),     W'({cout, overflow, zero}), W'(0));
      $display("bp cycle %0d: out_valid=%0d in_ready=%0d sum=%h", k, out_valid, in_ready, sum);
    end
    in_valid = 1'b1;                    // must not be accepted on DONE->IDLE edge
    release_result("bp");
    in_valid = 1'b0;
    chk("bp sum_held_in_idle", sum, 16'h2201);

    // Reset while idx == 2 in CALC.
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);                     // accept T, idx=0 afterwards
    @(negedge clk); in_valid = 1'b0;    // after T: idx 0
    @(negedge clk);                     // after T+1: idx 1
    @(negedge clk);                     // after T+2: idx 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstcalc out_valid", W'(out_valid), W'(0));
    chk("rstcalc in_ready",  W'(in_ready),  W'(1));
    chk("rstcalc sum",       sum,           W'(0));
    $display("reset in CALC: out_valid=%0d in_ready=%0d sum=%h", out_valid, in_ready, sum);
    start_and_wait(vecs[2], "post_rst");
    release_result("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port a  input  W  operand A, sampled only at accept.
REQ-005 SHALL have port b  input  W  operand B, sampled only at accept.
REQ-006 SHALL have port sub  input  1  0 = A+B, 1 = A-B; sampled only at accept.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  block can accept a request.
REQ-009 SHALL have port sum  output  W  result.
REQ-010 SHALL have port cout  output  1  carry out of bit W-1 (for subtract, 1 = no borrow).
REQ-011 SHALL have port overflow  output  1  two's-complement overflow.
REQ-012 SHALL have port zero  output  1  sum == 0.
REQ-013 SHALL have port out_valid  output  1  result and flags valid.
REQ-014 SHALL have port out_ready  input  1  consumer takes result.

Function
REQ-015 SHALL use exactly one instance of the team's combinational 4-bit CLA slice (CLA_FULL) and process one nibble per cycle, LSB nibble first.
REQ-016 SHALL implement states IDLE, CALC, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 Accept SHALL occur on an edge where in_valid && in_ready; a, b^{W{sub}} and sub SHALL be latched, nibble index set to 0, carry register set to sub, and IDLE -> CALC.
REQ-018 In CALC, each edge SHALL write the slice sum into nibble[idx] of the result accumulator, load the slice carry-out into the carry register, and increment idx.
REQ-019 When idx == NIBBLES-1 in CALC, that edge SHALL complete the last nibble, load sum/cout/overflow/zero output registers, and go CALC -> DONE.
REQ-020 Latency SHALL be exactly NIBBLES cycles: accept at edge T implies out_valid high after edge T+NIBBLES.
REQ-021 overflow SHALL equal (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is the latched, possibly inverted, B.
REQ-022 zero SHALL be computed on the full W-bit final sum.
REQ-023 In DONE, an edge with out_ready high SHALL go DONE -> IDLE; with out_ready low, state and all outputs SHALL hold.
REQ-024 in_valid SHALL be ignored outside IDLE; there is no accept in the same cycle as a DONE -> IDLE transition.
REQ-025 sum/cout/overflow/zero SHALL change only on the CALC -> DONE edge and hold their last result through IDLE.
REQ-026 Changes on a, b, or sub after accept SHALL NOT affect the operation in progress.
REQ-027 Arithmetic SHALL be modulo 2^W; no saturation.

Reset
REQ-028 An edge with rst high SHALL force IDLE, idx 0, carry 0, and sum/cout/overflow/zero 0, with priority over all other events.
REQ-029 Reset during CALC or DONE SHALL discard the operation; after the reset edge, in_ready = 1 and out_valid = 0.

Verification
REQ-030 Add: a=0x1234, b=0x0FCD, sub=0 -> out_valid after exactly 4 cycles; sum=0x2201, cout=0, overflow=0, zero=0.
REQ-031 Wrap: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, zero=1, overflow=0.
REQ-032 Subtract: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1, zero=0.
REQ-033 Positive overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, overflow=1.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and operands -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 Reset during CALC: assert rst while idx=2 -> after that edge out_valid=0, in_ready=1, sum=0; a new request then completes correctly in 4 cycles.
